// File: rtl/regread_stage_if.sv
// ID/EX pipeline-register channel between the register-read stage and EX.
// The master drives the latched instruction; the slave returns ex_ready.
interface regread_stage_if #(
    parameter int CTRL_W = 8
);
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_src1;
    logic [3:0]        ex_src2;
    logic              ex_use1;
    logic              ex_use2;
    logic [15:0]       ex_op1;
    logic [15:0]       ex_op2;
    logic [3:0]        ex_dst;
    logic              ex_we;
    logic              ex_is_load;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output ex_valid, ex_src1, ex_src2, ex_use1, ex_use2,
               ex_op1, ex_op2, ex_dst, ex_we, ex_is_load, ex_ctrl,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_src1, ex_src2, ex_use1, ex_use2,
               ex_op1, ex_op2, ex_dst, ex_we, ex_is_load, ex_ctrl,
        output ex_ready
    );
endinterface

// File: rtl/regread_stage.sv
// Register-read stage: selects operands with WB->ID bypass, inserts a bubble
// on load-use hazards, and keeps stalled operands fresh from writeback.
module regread_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [3:0]        id_dst,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [3:0]        rf_src1,
    output logic [3:0]        rf_src2,
    input  logic [15:0]       rf_data1,
    input  logic [15:0]       rf_data2,
    input  logic              wb_we,
    input  logic [3:0]        wb_dst,
    input  logic [15:0]       wb_data,
    regread_stage_if.master   ex
);

    // R0 reads as zero and is never bypassed; unused sources are zeroed too.
    function automatic logic [15:0] sel_operand(
        input logic        f_use,
        input logic [3:0]  f_src,
        input logic [15:0] f_rf_data,
        input logic        f_wb_we,
        input logic [3:0]  f_wb_dst,
        input logic [15:0] f_wb_data
    );
        logic [15:0] r;
        if (!f_use || (f_src == 4'd0)) begin
            r = 16'h0000;
        end else if (f_wb_we && (f_wb_dst == f_src)) begin
            r = f_wb_data;
        end else begin
            r = f_rf_data;
        end
        return r;
    endfunction

    function automatic logic wb_hits(
        input logic       f_wb_we,
        input logic [3:0] f_wb_dst,
        input logic       f_use,
        input logic [3:0] f_src
    );
        return f_wb_we && f_use && (f_src != 4'd0) && (f_wb_dst == f_src);
    endfunction

    logic              ex_valid_r;
    logic [3:0]        ex_src1_r;
    logic [3:0]        ex_src2_r;
    logic              ex_use1_r;
    logic              ex_use2_r;
    logic [15:0]       ex_op1_r;
    logic [15:0]       ex_op2_r;
    logic [3:0]        ex_dst_r;
    logic              ex_we_r;
    logic              ex_is_load_r;
    logic [CTRL_W-1:0] ex_ctrl_r;

    logic [15:0]       op1_s;
    logic [15:0]       op2_s;
    logic              ld_haz_s;
    logic              adv_s;
    logic              id_ready_s;
    logic              accept_s;

    // Operand select, hazard detection and the ID handshake.
    always_comb begin
        op1_s      = 16'h0000;
        op2_s      = 16'h0000;
        ld_haz_s   = 1'b0;
        adv_s      = 1'b0;
        id_ready_s = 1'b0;
        accept_s   = 1'b0;

        op1_s = sel_operand(id_use1, id_src1, rf_data1, wb_we, wb_dst, wb_data);
        op2_s = sel_operand(id_use2, id_src2, rf_data2, wb_we, wb_dst, wb_data);

        if (ex_valid_r && ex_is_load_r && ex_we_r && (ex_dst_r != 4'd0)) begin
            ld_haz_s = (id_use1 && (id_src1 == ex_dst_r)) ||
                       (id_use2 && (id_src2 == ex_dst_r));
        end else begin
            ld_haz_s = 1'b0;
        end

        adv_s      = !ex_valid_r || ex.ex_ready;
        id_ready_s = adv_s && !ld_haz_s && !flush;
        accept_s   = id_ready_s && id_valid;
    end

    // ID/EX pipeline register; flush beats load, load beats bubble/hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r   <= 1'b0;
            ex_src1_r    <= 4'd0;
            ex_src2_r    <= 4'd0;
            ex_use1_r    <= 1'b0;
            ex_use2_r    <= 1'b0;
            ex_op1_r     <= 16'h0000;
            ex_op2_r     <= 16'h0000;
            ex_dst_r     <= 4'd0;
            ex_we_r      <= 1'b0;
            ex_is_load_r <= 1'b0;
            ex_ctrl_r    <= {CTRL_W{1'b0}};
        end else if (flush) begin
            ex_valid_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r   <= 1'b1;
            ex_src1_r    <= id_src1;
            ex_src2_r    <= id_src2;
            ex_use1_r    <= id_use1;
            ex_use2_r    <= id_use2;
            ex_op1_r     <= op1_s;
            ex_op2_r     <= op2_s;
            ex_dst_r     <= id_dst;
            ex_we_r      <= id_we && (id_dst != 4'd0);
            ex_is_load_r <= id_is_load;
            ex_ctrl_r    <= id_ctrl;
        end else if (adv_s) begin
            ex_valid_r <= 1'b0;
        end else begin
            // Stalled: the register file write lands after our read, so
            // capture it here or EX would see a stale operand.
            if (wb_hits(wb_we, wb_dst, ex_use1_r, ex_src1_r)) begin
                ex_op1_r <= wb_data;
            end else begin
                ex_op1_r <= ex_op1_r;
            end
            if (wb_hits(wb_we, wb_dst, ex_use2_r, ex_src2_r)) begin
                ex_op2_r <= wb_data;
            end else begin
                ex_op2_r <= ex_op2_r;
            end
        end
    end

    assign id_ready      = id_ready_s;
    assign rf_src1       = id_src1;
    assign rf_src2       = id_src2;

    assign ex.ex_valid   = ex_valid_r;
    assign ex.ex_src1    = ex_src1_r;
    assign ex.ex_src2    = ex_src2_r;
    assign ex.ex_use1    = ex_use1_r;
    assign ex.ex_use2    = ex_use2_r;
    assign ex.ex_op1     = ex_op1_r;
    assign ex.ex_op2     = ex_op2_r;
    assign ex.ex_dst     = ex_dst_r;
    assign ex.ex_we      = ex_we_r;
    assign ex.ex_is_load = ex_is_load_r;
    assign ex.ex_ctrl    = ex_ctrl_r;

endmodule

// File: tb/tb_regread_stage.sv
// Scoreboard bench for regread_stage: directed ID vectors push expected EX
// contents; a negedge monitor pops and compares on each EX handshake.
module tb_regread_stage;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        use1;
        logic        use2;
        logic [3:0]  dst;
        logic        we;
        logic        ld;
        logic [7:0]  ctrl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_src1, id_src2;
    logic        id_use1, id_use2;
    logic [3:0]  id_dst;
    logic        id_we, id_is_load;
    logic [7:0]  id_ctrl;
    logic [3:0]  rf_src1, rf_src2;
    logic [15:0] rf_data1, rf_data2;
    logic        wb_we;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    regread_stage_if #(.CTRL_W(8)) ex_bus ();

    regread_stage #(.CTRL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_use1    (id_use1),
        .id_use2    (id_use2),
        .id_dst     (id_dst),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .id_ctrl    (id_ctrl),
        .rf_src1    (rf_src1),
        .rf_src2    (rf_src2),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .wb_we      (wb_we),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .ex         (ex_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every EX handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && ex_bus.ex_valid && ex_bus.ex_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ex_op1", {16'h0, ex_bus.ex_op1}, {16'h0, e.op1});
                chk("ex_op2", {16'h0, ex_bus.ex_op2}, {16'h0, e.op2});
                chk("ex_fields",
                    {8'h0, ex_bus.ex_src1, ex_bus.ex_src2, ex_bus.ex_use1, ex_bus.ex_use2,
                     ex_bus.ex_dst, ex_bus.ex_we, ex_bus.ex_is_load, ex_bus.ex_ctrl},
                    {8'h0, e.src1, e.src2, e.use1, e.use2, e.dst, e.we, e.ld, e.ctrl});
            end
        end
    end

    // Present one ID instruction for one cycle; called at posedge+1.
    task automatic present(input logic [3:0] s1, input logic [3:0] s2,
                           input logic u1, input logic u2,
                           input logic [3:0] d, input logic w, input logic ld,
                           input logic [7:0] c,
                           input logic [15:0] r1, input logic [15:0] r2,
                           input logic exp_rdy, input logic push_it,
                           input logic [15:0] e1, input logic [15:0] e2);
        exp_t e;
        id_valid = 1'b1; id_src1 = s1; id_src2 = s2; id_use1 = u1; id_use2 = u2;
        id_dst = d; id_we = w; id_is_load = ld; id_ctrl = c;
        rf_data1 = r1; rf_data2 = r2;
        @(negedge clk);
        chk("id_ready", {31'h0, id_ready}, {31'h0, exp_rdy});
        chk("rf_src", {24'h0, rf_src1, rf_src2}, {24'h0, s1, s2});
        if (exp_rdy && push_it) begin
            e.op1 = e1; e.op2 = e2; e.src1 = s1; e.src2 = s2; e.use1 = u1; e.use2 = u2;
            e.dst = d; e.we = w && (d != 4'd0); e.ld = ld; e.ctrl = c;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_src1 = 4'd0; id_src2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        id_dst = 4'd0; id_we = 1'b0; id_is_load = 1'b0; id_ctrl = 8'h00;
        rf_data1 = 16'h0000; rf_data2 = 16'h0000;
        wb_we = 1'b0; wb_dst = 4'd0; wb_data = 16'h0000;
        ex_bus.ex_ready = 1'b1;
        #3;
        chk("reset_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd0);
        chk("reset_ex_ops", {ex_bus.ex_op1, ex_bus.ex_op2}, 32'd0);
        chk("reset_id_ready", {31'h0, id_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic flow, one-cycle latency
        present(4'd3, 4'd4, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 8'h11,
                16'h1234, 16'h00FF, 1'b1, 1'b1, 16'h1234, 16'h00FF);
        idle();
        chk("latency_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd1);

        // WB bypass, R0, unused source, both-source bypass, wb_we low
        wb_we = 1'b1; wb_dst = 4'd5; wb_data = 16'hBEEF;
        present(4'd5, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 8'h21,
                16'h0000, 16'h7777, 1'b1, 1'b1, 16'hBEEF, 16'h0000);
        wb_dst = 4'd0;
        present(4'd0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'h22,
                16'h1111, 16'h5555, 1'b1, 1'b1, 16'h0000, 16'h0000);
        wb_dst = 4'd8;
        present(4'd8, 4'd8, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 8'h23,
                16'h1111, 16'h2222, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF);
        wb_we = 1'b0;
        present(4'd8, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 8'h24,
                16'h1111, 16'h2222, 1'b1, 1'b1, 16'h1111, 16'h2222);
        idle();

        // Load-use: exactly one bubble
        present(4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 8'h30,
                16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000);
        present(4'd2, 4'd6, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 8'h31,
                16'h0202, 16'h0606, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("bubble_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd0);
        present(4'd2, 4'd6, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 8'h31,
                16'h0202, 16'h0606, 1'b1, 1'b1, 16'h0202, 16'h0606);
        idle();

        // Load followed by independent instruction (unused src1 matches dst)
        present(4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 8'h32,
                16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000);
        present(4'd6, 4'd7, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 8'h33,
                16'h0606, 16'h0707, 1'b1, 1'b1, 16'h0000, 16'h0707);
        idle();

        // EX stall with WB refresh of op1
        present(4'd2, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 8'h44,
                16'h0202, 16'h0303, 1'b1, 1'b1, 16'hA5A5, 16'h0303);
        ex_bus.ex_ready = 1'b0;
        present(4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'h55,
                16'h0101, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("stall_hold_op1", {16'h0, ex_bus.ex_op1}, 32'h0202);
        wb_we = 1'b1; wb_dst = 4'd2; wb_data = 16'hA5A5;
        present(4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'h55,
                16'h0101, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wb_we = 1'b0;
        chk("refresh_op1", {16'h0, ex_bus.ex_op1}, 32'hA5A5);
        chk("refresh_op2_held", {16'h0, ex_bus.ex_op2}, 32'h0303);
        present(4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'h55,
                16'h0101, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        ex_bus.ex_ready = 1'b1;
        present(4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'h55,
                16'h0101, 16'h0000, 1'b1, 1'b1, 16'h0101, 16'h0000);

        // Flush wins over a valid, acceptable ID instruction
        flush = 1'b1;
        present(4'd3, 4'd4, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 8'h66,
                16'h3333, 16'h4444, 1'b0, 1'b0, 16'h0000, 16'h0000);
        flush = 1'b0;
        idle();
        chk("flush_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd0);

        // Async reset mid-stall drops the held instruction immediately
        present(4'd3, 4'd4, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 8'h77,
                16'h3333, 16'h4444, 1'b1, 1'b0, 16'h0000, 16'h0000);
        idle();
        ex_bus.ex_ready = 1'b0;
        chk("pre_reset_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, ex_bus.ex_valid}, 32'd0);
        chk("async_rst_ops", {ex_bus.ex_op1, ex_bus.ex_op2}, 32'd0);
        chk("async_rst_fields",
            {8'h0, ex_bus.ex_src1, ex_bus.ex_src2, ex_bus.ex_use1, ex_bus.ex_use2,
             ex_bus.ex_dst, ex_bus.ex_we, ex_bus.ex_is_load, ex_bus.ex_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ex_bus.ex_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ex_valid", {31'h0, ex_bus.ex_valid}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
